// File: rtl/flex_counter_pkg.sv
// flex_counter_pkg: shared direction and mode types for the flex counter bank.
package flex_counter_pkg;
    typedef enum logic {CNT_UP = 1'b0, CNT_DOWN = 1'b1} cnt_dir_t;
    typedef enum logic {CNT_WRAP = 1'b0, CNT_ONESHOT = 1'b1} cnt_mode_t;
endpackage

// File: rtl/flex_counter_ch.sv
// flex_counter_ch: one counter channel with up/down, wrap/one-shot, load and sticky event.
module flex_counter_ch
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  cnt_dir_t                dir,
    input  cnt_mode_t               mode,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    input  logic                    evt_clr,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    evt_pend,
    output logic                    next_pend
);
    localparam int W = NUM_CNT_BITS;
    logic [W-1:0] step, next_count, terminal;
    logic         next_flag;
    always_comb begin
        step = count_out;
        // a zero rollover value parks the channel regardless of direction
        if (rollover_val != '0)
            step = (dir == CNT_UP)
                 ? ((count_out < rollover_val) ? count_out + W'(1) : ((mode == CNT_WRAP) ? W'(1) : count_out))
                 : ((count_out > W'(1)) ? count_out - W'(1) : ((mode == CNT_WRAP) ? rollover_val : count_out));
        next_count = clear ? '0 : load ? load_val : count_enable ? step : count_out;
        terminal   = (dir == CNT_DOWN) ? W'(1) : rollover_val;
        next_flag  = (next_count == terminal) && (rollover_val != '0);
        next_pend  = (next_flag & ~rollover_flag) | (evt_pend & ~evt_clr);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
            evt_pend      <= 1'b0;
        end else begin
            count_out     <= next_count;
            rollover_flag <= next_flag;
            evt_pend      <= next_pend;
        end
    end
endmodule

// File: rtl/flex_counter_bank.sv
// flex_counter_bank: NUM_CH independent flex counter channels with an aggregated interrupt.
module flex_counter_bank
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CH       = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              clear,
    input  logic [NUM_CH-1:0]              load,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CH-1:0]              count_enable,
    input  logic [NUM_CH-1:0]              dir,
    input  logic [NUM_CH-1:0]              mode,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
    input  logic [NUM_CH-1:0]              evt_clr,
    output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
    output logic [NUM_CH-1:0]              rollover_flag,
    output logic [NUM_CH-1:0]              evt_pend,
    output logic                           irq
);
    localparam int W = NUM_CNT_BITS;
    logic [NUM_CH-1:0] next_pend;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        flex_counter_ch #(.NUM_CNT_BITS(W)) u_ch (
            .clk          (clk),
            .rst          (rst),
            .clear        (clear[i]),
            .load         (load[i]),
            .load_val     (load_val[i*W +: W]),
            .count_enable (count_enable[i]),
            .dir          (cnt_dir_t'(dir[i])),
            .mode         (cnt_mode_t'(mode[i])),
            .rollover_val (rollover_val[i*W +: W]),
            .evt_clr      (evt_clr[i]),
            .count_out    (count_out[i*W +: W]),
            .rollover_flag(rollover_flag[i]),
            .evt_pend     (evt_pend[i]),
            .next_pend    (next_pend[i])
        );
    end
    // irq follows next pend state so it lines up with evt_pend
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq <= 1'b0;
        else     irq <= |next_pend;
    end
endmodule

// File: tb/tb_flex_counter_bank.sv
// tb_flex_counter_bank: scoreboard bench with directed vectors for a 2-channel, 4-bit bank.
module tb_flex_counter_bank;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] clear = '0, load = '0, count_enable = '0, dir = '0, mode = '0, evt_clr = '0;
    logic [7:0] load_val = '0, rollover_val = '0;
    logic [7:0] count_out;
    logic [1:0] rollover_flag, evt_pend;
    logic       irq;
    int         total = 0, passed = 0;

    typedef struct {
        logic [12:0] v;
        string       name;
    } exp_t;
    exp_t q[$];

    flex_counter_bank #(.NUM_CNT_BITS(4), .NUM_CH(2)) dut (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .count_enable(count_enable), .dir(dir), .mode(mode), .rollover_val(rollover_val),
        .evt_clr(evt_clr), .count_out(count_out), .rollover_flag(rollover_flag),
        .evt_pend(evt_pend), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got cnt=%h flag=%b pend=%b irq=%b, expected cnt=%h flag=%b pend=%b irq=%b",
                      name, got[12:5], got[4:3], got[2:1], got[0], exp[12:5], exp[4:3], exp[2:1], exp[0]);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.name, {count_out, rollover_flag, evt_pend, irq}, e.v);
        end
    end

    task automatic step(input logic [1:0] cl, input logic [1:0] ld, input logic [7:0] lv,
                        input logic [1:0] en, input logic [1:0] dr, input logic [1:0] md,
                        input logic [7:0] rv, input logic [1:0] ec,
                        input logic [7:0] ec_cnt, input logic [1:0] ef, input logic [1:0] ep,
                        input logic ei, input string name);
        exp_t e;
        @(negedge clk);
        clear = cl; load = ld; load_val = lv; count_enable = en; dir = dr;
        mode = md; rollover_val = rv; evt_clr = ec;
        e.v = {ec_cnt, ef, ep, ei};
        e.name = name;
        q.push_back(e);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(0, 0, 8'h00, 0, 0, 0, 8'h05, 0, 8'h00, 0, 0, 0, "idle_hold");
        step(0, 0, 8'h00, 1, 0, 0, 8'h05, 0, 8'h01, 0, 0, 0, "up_1");
        step(0, 0, 8'h00, 1, 0, 0, 8'h05, 0, 8'h02, 0, 0, 0, "up_2");
        step(0, 0, 8'h00, 1, 0, 0, 8'h05, 0, 8'h03, 0, 0, 0, "up_3");
        step(0, 0, 8'h00, 1, 0, 0, 8'h05, 0, 8'h04, 0, 0, 0, "up_4");
        step(0, 0, 8'h00, 1, 0, 0, 8'h05, 0, 8'h05, 1, 1, 1, "up_5_flag");
        step(0, 0, 8'h00, 1, 0, 0, 8'h05, 0, 8'h01, 0, 1, 1, "up_wrap_1");
        step(0, 0, 8'h00, 1, 0, 0, 8'h05, 0, 8'h02, 0, 1, 1, "up_wrap_2");
        step(0, 0, 8'h00, 1, 0, 0, 8'h05, 0, 8'h03, 0, 1, 1, "up_wrap_3");
        step(0, 0, 8'h00, 1, 0, 0, 8'h05, 0, 8'h04, 0, 1, 1, "up_wrap_4");
        step(0, 0, 8'h00, 1, 0, 0, 8'h05, 0, 8'h05, 1, 1, 1, "up_wrap_5");
        step(0, 0, 8'h00, 0, 0, 0, 8'h05, 0, 8'h05, 1, 1, 1, "hold_at_5_a");
        step(0, 0, 8'h00, 0, 0, 0, 8'h05, 0, 8'h05, 1, 1, 1, "hold_at_5_b");
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset", {count_out, rollover_flag, evt_pend, irq}, 13'h0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 8'h00, 0, 0, 0, 8'h05, 0, 8'h00, 0, 0, 0, "post_reset_hold");
        step(0, 1, 8'h03, 0, 1, 1, 8'h05, 0, 8'h03, 0, 0, 0, "dn_load_3");
        step(0, 0, 8'h00, 1, 1, 1, 8'h05, 0, 8'h02, 0, 0, 0, "dn_2");
        step(0, 0, 8'h00, 1, 1, 1, 8'h05, 0, 8'h01, 1, 1, 1, "dn_1_flag");
        step(0, 0, 8'h00, 1, 1, 1, 8'h05, 0, 8'h01, 1, 1, 1, "dn_oneshot_hold_a");
        step(0, 0, 8'h00, 1, 1, 1, 8'h05, 0, 8'h01, 1, 1, 1, "dn_oneshot_hold_b");
        step(0, 0, 8'h00, 1, 1, 1, 8'h05, 1, 8'h01, 1, 0, 0, "dn_evt_clr");
        step(0, 0, 8'h00, 1, 1, 1, 8'h05, 0, 8'h01, 1, 0, 0, "dn_no_reset_while_held");
        step(1, 1, 8'h09, 1, 1, 1, 8'h05, 0, 8'h00, 0, 0, 0, "clear_beats_load_en");
        step(0, 1, 8'h0c, 0, 0, 0, 8'h05, 0, 8'h0c, 0, 0, 0, "load_above_rv");
        step(0, 0, 8'h00, 1, 0, 0, 8'h05, 0, 8'h01, 0, 0, 0, "out_of_range_wrap");
        step(0, 0, 8'h00, 1, 0, 0, 8'h05, 0, 8'h02, 0, 0, 0, "recover_2");
        step(0, 0, 8'h00, 1, 0, 0, 8'h05, 0, 8'h03, 0, 0, 0, "recover_3");
        step(0, 0, 8'h00, 1, 0, 0, 8'h05, 0, 8'h04, 0, 0, 0, "recover_4");
        step(0, 0, 8'h00, 1, 0, 0, 8'h05, 1, 8'h05, 1, 1, 1, "set_beats_evt_clr");
        step(0, 0, 8'h00, 0, 0, 0, 8'h05, 1, 8'h05, 1, 0, 0, "evt_clr_alone");
        step(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, "rv0_clear");
        step(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, "rv0_up_hold");
        step(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, "rv0_down_hold");
        step(0, 1, 8'h0e, 0, 0, 0, 8'h0f, 0, 8'h0e, 0, 0, 0, "rv15_load_14");
        step(0, 0, 8'h00, 1, 0, 0, 8'h0f, 0, 8'h0f, 1, 1, 1, "rv15_up_15");
        step(0, 0, 8'h00, 1, 0, 0, 8'h0f, 0, 8'h01, 0, 1, 1, "rv15_wrap_1");
        step(1, 0, 8'h00, 0, 1, 0, 8'h0f, 1, 8'h00, 0, 0, 0, "dn_wrap_clear");
        step(0, 0, 8'h00, 1, 1, 0, 8'h0f, 0, 8'h0f, 0, 0, 0, "dn_from_0_wrap");
        step(0, 0, 8'h00, 1, 1, 0, 8'h0f, 0, 8'h0e, 0, 0, 0, "dn_after_wrap");
        step(3, 0, 8'h00, 0, 2, 0, 8'h23, 0, 8'h00, 0, 0, 0, "mc_clear");
        step(0, 0, 8'h00, 1, 2, 0, 8'h23, 0, 8'h01, 0, 0, 0, "mc_en0");
        step(0, 0, 8'h00, 2, 2, 0, 8'h23, 0, 8'h21, 0, 0, 0, "mc_en1_wrap");
        step(0, 0, 8'h00, 3, 2, 0, 8'h23, 0, 8'h12, 2, 2, 1, "mc_en_both");
        step(0, 0, 8'h00, 1, 2, 0, 8'h23, 0, 8'h13, 3, 3, 1, "mc_ch0_term");
        step(0, 0, 8'h00, 2, 2, 0, 8'h23, 1, 8'h23, 1, 2, 1, "mc_clr0_irq_tracks1");
        step(0, 0, 8'h00, 0, 2, 0, 8'h23, 2, 8'h23, 1, 0, 0, "mc_clr1_irq_low");
        step(0, 0, 8'h00, 1, 2, 0, 8'h23, 0, 8'h21, 0, 0, 0, "mc_ch0_wrap");
        step(0, 0, 8'h00, 3, 2, 0, 8'h23, 0, 8'h12, 2, 2, 1, "mc_ch1_rise");
        step(0, 0, 8'h00, 0, 2, 0, 8'h23, 0, 8'h12, 2, 2, 1, "mc_idle");
        for (int n = 0; n < 20 && q.size() != 0; n++) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
